// File: rtl/subword_store_unit_if.sv
// Store request / data memory bundle for subword_store_unit.
// The slave view is the store unit; the master view is the datapath plus memory.
interface subword_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_rdata,
        output req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/subword_store_unit.sv
// SB/SH/SW store unit: word stores write directly, sub-word stores read-modify-write
// the containing memory word with big-endian lane placement.
module subword_store_unit (
    input  logic                clk,
    input  logic                rst_n,
    subword_store_unit_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] MERGE = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic [31:0] merged_q;
    logic [31:0] merged_d;
    logic        misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane 0 is the most significant byte; only byte/half sizes ever reach MERGE.
    always_comb begin
        merged_d = bus.mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged_d[31:24] = wdata_q[7:0];
                2'b01:   merged_d[23:16] = wdata_q[7:0];
                2'b10:   merged_d[15:8]  = wdata_q[7:0];
                default: merged_d[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged_d[15:0] = wdata_q[15:0];
        end else begin
            merged_d[31:16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            merged_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        if (misaligned)
                            state <= ERR;
                        else if (bus.req_size == 2'b10)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ:  state <= MERGE;
                MERGE: begin
                    merged_q <= merged_d;
                    state    <= WRITE;
                end
                WRITE:   state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_rd_en = (state == READ);
    assign bus.mem_wr_en = (state == WRITE);
    assign bus.done      = (state == WRITE) || (state == ERR);
    assign bus.err       = (state == ERR);
    assign bus.mem_addr  = addr_q[31:2];
    assign bus.mem_wdata = (state != WRITE)     ? '0      :
                           (size_q == 2'b10)    ? wdata_q : merged_q;
endmodule
